// File: rtl/elevator_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// elevator_dispatch_ctrl
//
// Two-car scheduler for a 9-floor building. Hall calls are latched into a
// pending mask. Each cycle, one pending call that no car is already serving
// is handed to an idle car. Car 1 has priority. The chosen floor is the one
// nearest to the car, and the lower floor wins a tie. Each car then moves
// one floor per MOVE_TICKS cycles and holds its door open for DOOR_TICKS
// cycles.
//
// Parameters:
//   MOVE_TICKS  clock cycles per one-floor move (>= 2)
//   DOOR_TICKS  clock cycles the door stays open (>= 2)
//
// Ports:
//   clk                      system clock
//   reset                    asynchronous, active-high reset
//   call_req   [8:0]         hall-call requests; bit i = floor i+1
//   elv1_floor / elv2_floor  car position, 1..9
//   elv1_state / elv2_state  0 IDLE, 1 UP, 2 DOWN, 3 DOOR
//   elv1_door  / elv2_door   high while the car is in DOOR
//   pending    [8:0]         latched, not yet served calls
//
// Build option:
//   SWEEP_PICKUP_EN  A moving car stops at an intermediate floor that has an
//                    unassigned pending call. After the door dwell, the car
//                    continues in the same direction towards its original
//                    target.
// ---------------------------------------------------------------------------
module elevator_dispatch_ctrl #(
   parameter logic [23:0] MOVE_TICKS = 24'd5_000_000,
   parameter logic [23:0] DOOR_TICKS = 24'd10_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [8:0] call_req,
   output logic [4:0] elv1_floor,
   output logic [4:0] elv2_floor,
   output logic [1:0] elv1_state,
   output logic [1:0] elv2_state,
   output logic       elv1_door,
   output logic       elv2_door,
   output logic [8:0] pending
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2,
      ST_DOOR = 2'd3
   } car_state_t;

   localparam int NCARS = 2;

   car_state_t  state_q  [NCARS];
   car_state_t  state_d  [NCARS];
   logic [4:0]  floor_q  [NCARS];
   logic [4:0]  floor_d  [NCARS];
   logic [23:0] timer_q  [NCARS];
   logic [23:0] timer_d  [NCARS];
   logic [8:0]  target_q [NCARS];
   logic [8:0]  target_d [NCARS];
   logic        door_q   [NCARS];
   logic [8:0]  clear_v  [NCARS];

   logic [8:0]  pending_q;
   logic [8:0]  pending_d;

   logic [8:0]       assigned_mask;
   logic [8:0]       unassigned;
   logic [NCARS-1:0] grant;
   logic [4:0]       pick_from;
   logic [4:0]       pick_floor;
   logic [8:0]       pick_onehot;
   logic [4:0]       best_dist;
   logic [4:0]       cand_floor;
   logic [4:0]       cand_dist;
   logic [4:0]       nf;

`ifdef SWEEP_PICKUP_EN
   logic        resume_q [NCARS];
   logic        resume_d [NCARS];
   car_state_t  dir_q    [NCARS];
   car_state_t  dir_d    [NCARS];
   logic [8:0]  sweep_avail;

   // The floor the arbiter is handing out this cycle is excluded. This keeps
   // one call from being served by two cars on the same edge.
   assign sweep_avail = unassigned & ~((|grant) ? pick_onehot : 9'h000);
`endif

   function automatic logic [8:0] floor_onehot(input logic [4:0] fl);
      logic [8:0] oh;
      oh = '0;
      for (int f = 0; f < 9; f++) begin
         if (fl == 5'(f + 1)) oh[f] = 1'b1;
      end
      return oh;
   endfunction

   // Arbiter: at most one assignment per cycle. Car 1 is evaluated first.
   always_comb begin
      assigned_mask = '0;
      for (int c = 0; c < NCARS; c++) begin
         if (state_q[c] != ST_IDLE) assigned_mask = assigned_mask | target_q[c];
      end
      unassigned = pending_q & ~assigned_mask;

      grant     = '0;
      pick_from = floor_q[0];
      if (state_q[0] == ST_IDLE && (|unassigned)) begin
         grant[0] = 1'b1;
      end else if (state_q[1] == ST_IDLE && (|unassigned)) begin
         grant[1]  = 1'b1;
         pick_from = floor_q[1];
      end

      // The scan runs from floor 1 upward and uses a strict compare, so the
      // lower floor wins a distance tie.
      pick_floor = 5'd1;
      best_dist  = 5'd31;
      cand_floor = '0;
      cand_dist  = '0;
      for (int f = 0; f < 9; f++) begin
         cand_floor = 5'(f + 1);
         cand_dist  = (cand_floor > pick_from) ? (cand_floor - pick_from)
                                               : (pick_from - cand_floor);
         if (unassigned[f] && (cand_dist < best_dist)) begin
            best_dist  = cand_dist;
            pick_floor = cand_floor;
         end
      end
      pick_onehot = floor_onehot(pick_floor);
   end

   // Per-car next-state logic.
   always_comb begin
      nf = 5'd1;
      for (int c = 0; c < NCARS; c++) begin
         state_d[c]  = state_q[c];
         floor_d[c]  = floor_q[c];
         timer_d[c]  = timer_q[c];
         target_d[c] = target_q[c];
         clear_v[c]  = '0;
`ifdef SWEEP_PICKUP_EN
         resume_d[c] = resume_q[c];
         dir_d[c]    = dir_q[c];
`endif
         // Next floor saturates inside 1..9.
         if (state_q[c] == ST_UP)
            nf = (floor_q[c] < 5'd9) ? (floor_q[c] + 5'd1) : 5'd9;
         else
            nf = (floor_q[c] > 5'd1) ? (floor_q[c] - 5'd1) : 5'd1;

         case (state_q[c])
            ST_IDLE: begin
               if (grant[c]) begin
                  target_d[c] = pick_onehot;
                  if (pick_floor == floor_q[c]) begin
                     state_d[c] = ST_DOOR;
                     timer_d[c] = DOOR_TICKS - 24'd1;
                     clear_v[c] = pick_onehot;
                  end else if (pick_floor > floor_q[c]) begin
                     state_d[c] = ST_UP;
                     timer_d[c] = MOVE_TICKS - 24'd1;
                  end else begin
                     state_d[c] = ST_DOWN;
                     timer_d[c] = MOVE_TICKS - 24'd1;
                  end
               end
            end
            ST_UP, ST_DOWN: begin
               if (timer_q[c] != 24'd0) begin
                  timer_d[c] = timer_q[c] - 24'd1;
               end else begin
                  floor_d[c] = nf;
                  if (floor_onehot(nf) == target_q[c]) begin
                     state_d[c] = ST_DOOR;
                     timer_d[c] = DOOR_TICKS - 24'd1;
                     clear_v[c] = target_q[c];
                  end
`ifdef SWEEP_PICKUP_EN
                  else if (|(sweep_avail & floor_onehot(nf))) begin
                     state_d[c]  = ST_DOOR;
                     timer_d[c]  = DOOR_TICKS - 24'd1;
                     clear_v[c]  = floor_onehot(nf);
                     resume_d[c] = 1'b1;
                     dir_d[c]    = state_q[c];
                  end
`endif
                  else begin
                     timer_d[c] = MOVE_TICKS - 24'd1;
                  end
               end
            end
            ST_DOOR: begin
               if (timer_q[c] != 24'd0) begin
                  timer_d[c] = timer_q[c] - 24'd1;
               end else begin
`ifdef SWEEP_PICKUP_EN
                  // An intermediate stop keeps its target, so the car leaves
                  // in its original direction instead of going idle.
                  if (resume_q[c]) begin
                     state_d[c]  = dir_q[c];
                     timer_d[c]  = MOVE_TICKS - 24'd1;
                     resume_d[c] = 1'b0;
                  end else begin
                     state_d[c] = ST_IDLE;
                  end
`else
                  // Going IDLE releases the target: the assigned mask only
                  // counts cars that are not idle.
                  state_d[c] = ST_IDLE;
`endif
               end
            end
            default: begin
               state_d[c] = ST_IDLE;
            end
         endcase
      end
   end

   // A car entering DOOR clears the call on the same edge. The clear has
   // priority over a call that is still being held.
   always_comb begin
      pending_d = (pending_q | call_req) & ~(clear_v[0] | clear_v[1]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q <= '0;
         for (int c = 0; c < NCARS; c++) begin
            state_q[c]  <= ST_IDLE;
            floor_q[c]  <= 5'd1;
            timer_q[c]  <= '0;
            target_q[c] <= 9'h001;
            door_q[c]   <= 1'b0;
`ifdef SWEEP_PICKUP_EN
            resume_q[c] <= 1'b0;
            dir_q[c]    <= ST_UP;
`endif
         end
      end else begin
         pending_q <= pending_d;
         for (int c = 0; c < NCARS; c++) begin
            state_q[c]  <= state_d[c];
            floor_q[c]  <= floor_d[c];
            timer_q[c]  <= timer_d[c];
            target_q[c] <= target_d[c];
            door_q[c]   <= (state_d[c] == ST_DOOR);
`ifdef SWEEP_PICKUP_EN
            resume_q[c] <= resume_d[c];
            dir_q[c]    <= dir_d[c];
`endif
         end
      end
   end

   assign elv1_floor = floor_q[0];
   assign elv2_floor = floor_q[1];
   assign elv1_state = state_q[0];
   assign elv2_state = state_q[1];
   assign elv1_door  = door_q[0];
   assign elv2_door  = door_q[1];
   assign pending    = pending_q;

endmodule
